// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter; define TX_PARITY_EN to add an even-parity bit (8E1)
`timescale 1ns/1ps
module uart_tx #(
    parameter int CLOCKS_PER_BIT = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy
);
    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            bit_end;
`ifdef TX_PARITY_EN
    logic            parity;
`endif

    assign bit_end = bit_cnt == LAST;

    // frame sequencer: every line bit is held for CLOCKS_PER_BIT clocks, outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_serial <= 1'b1;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
        end else begin
            bit_cnt <= (state == IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
            case (state)
                IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        state     <= START;
                        shift_reg <= tx_data;
`ifdef TX_PARITY_EN
                        parity    <= ^tx_data;
`endif
                        tx_serial <= 1'b0;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                START: if (bit_end) begin
                    state     <= DATA;
                    tx_serial <= shift_reg[0];
                end
                DATA: if (bit_end) begin
                    bit_idx   <= bit_idx + 1'b1;
                    shift_reg <= shift_reg >> 1;
                    if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                        state     <= PARITY;
                        tx_serial <= parity;
`else
                        state     <= STOP;
                        tx_serial <= 1'b1;
`endif
                    end else begin
                        tx_serial <= shift_reg[1];
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: if (bit_end) begin
                    state     <= STOP;
                    tx_serial <= 1'b1;
                end
`endif
                STOP: if (bit_end) begin
                    state    <= IDLE;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
